udma_lin_tx_arbiter: RTL and testbench

Round-robin arbiter and response router for the uDMA linear TX channels. Collects read requests from all TX linear channels (UART, QSPIM data/cmd, I2C data/cmd, HYPER, indexed by the package CH_ID_LIN_TX_* values). Issues them one at a time to the L2 read port. Routes each L2 response back to the originating channel in order. Sits between the per-channel TX engines and the L2 memory interface.

---
 rtl/udma_lin_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_udma_lin_tx_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_lin_tx_arbiter.sv
// Round-robin arbiter for the uDMA linear TX channels: serialises channel reads onto the
// L2 read port and routes in-order responses back through an ID FIFO.
module udma_lin_tx_arbiter #(
    parameter int unsigned N_CH   = 19,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OUTSTD = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [N_CH-1:0]          ch_req_i,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
    input  logic [N_CH*2-1:0]        ch_size_i,
    output logic [N_CH-1:0]          ch_gnt_o,
    output logic [N_CH-1:0]          ch_valid_o,
    output logic [DATA_W-1:0]        ch_data_o,
    output logic                     l2_req_o,
    output logic [ADDR_W-1:0]        l2_addr_o,
    output logic [3:0]               l2_be_o,
    input  logic                     l2_gnt_i,
    input  logic [DATA_W-1:0]        l2_rdata_i,
    input  logic                     l2_rvalid_i,
    output logic                     rsp_err_o
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PTR_W = $clog2(OUTSTD);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [CH_W:0]   N_CH_EXT = (CH_W + 1)'(N_CH);

    typedef struct packed {
        logic [CH_W-1:0] id;
        logic [1:0]      off;
        logic [1:0]      size;
    } fifo_entry_t;

    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    fifo_entry_t       fifo_q [OUTSTD];
    fifo_entry_t       head;
    logic              rsp_err_q;

    logic              win_found;
    logic [CH_W-1:0]   win_id;
    logic [CH_W:0]     cand;
    logic [ADDR_W-1:0] win_addr;
    logic [1:0]        win_size;
    logic              any_req, fifo_full, fifo_empty, push, pop;
    logic [DATA_W-1:0] shifted;

    // Search from ptr upward; cand never exceeds 2*(N_CH-1) so one subtraction wraps it.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, ptr_q} + (CH_W + 1)'(k);
            if (cand >= N_CH_EXT) begin
                cand = cand - N_CH_EXT;
            end
            if (!win_found && ch_req_i[cand[CH_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_size = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win_id == CH_W'(i)) begin
                win_addr = ch_addr_i[i*ADDR_W +: ADDR_W];
                win_size = ch_size_i[2*i +: 2];
            end
        end
    end

    assign any_req    = |ch_req_i;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];

    assign push = l2_req_o & l2_gnt_i;
    assign pop  = l2_rvalid_i & ~fifo_empty;

    always_comb begin
        l2_req_o  = any_req & ~fifo_full;
        l2_addr_o = '0;
        l2_be_o   = '0;
        ch_gnt_o  = '0;
        if (any_req) begin
            l2_addr_o = {win_addr[ADDR_W-1:2], 2'b00};
            unique case (win_size)
                2'd0:    l2_be_o = 4'b0001 << win_addr[1:0];
                2'd1:    l2_be_o = 4'b0011 << win_addr[1:0];
                default: l2_be_o = 4'b1111;
            endcase
        end
        if (push) begin
            ch_gnt_o[win_id] = 1'b1;
        end
    end

    assign shifted = l2_rdata_i >> {head.off, 3'b000};

    always_comb begin
        ch_valid_o = '0;
        ch_data_o  = '0;
        if (pop) begin
            ch_valid_o[head.id] = 1'b1;
            unique case (head.size)
                2'd0:    ch_data_o = DATA_W'(shifted[7:0]);
                2'd1:    ch_data_o = DATA_W'(shifted[15:0]);
                default: ch_data_o = shifted;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (push) begin
            ptr_d = (win_id == LAST_CH) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            wr_ptr_q  <= wr_ptr_q + (PTR_W + 1)'(push);
            rd_ptr_q  <= rd_ptr_q + (PTR_W + 1)'(pop);
            rsp_err_q <= rsp_err_q | (l2_rvalid_i & fifo_empty);
        end
    end

    // Payload needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{id: win_id, off: win_addr[1:0], size: win_size};
        end
    end

    assign rsp_err_o = rsp_err_q;

endmodule

// File: tb/tb_udma_lin_tx_arbiter.sv
// Bench for udma_lin_tx_arbiter: directed scenarios plus randomized traffic against a
// queue-based round-robin reference model.
module tb_udma_lin_tx_arbiter;

    localparam int N_CH   = 19;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OUTSTD = 4;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b1;
    logic [N_CH-1:0]        ch_req;
    logic [31:0]            a_addr [N_CH];
    logic [1:0]             a_size [N_CH];
    logic [N_CH*ADDR_W-1:0] ch_addr_flat;
    logic [N_CH*2-1:0]      ch_size_flat;
    logic [N_CH-1:0]        ch_gnt, ch_valid;
    logic [DATA_W-1:0]      ch_data;
    logic                   l2_req, l2_gnt, l2_rvalid, rsp_err;
    logic [ADDR_W-1:0]      l2_addr;
    logic [3:0]             l2_be;
    logic [DATA_W-1:0]      l2_rdata;

    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign ch_addr_flat[g*ADDR_W +: ADDR_W] = a_addr[g];
        assign ch_size_flat[2*g +: 2]           = a_size[g];
    end

    always #5 clk = ~clk;

    udma_lin_tx_arbiter #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTSTD(OUTSTD)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .ch_req_i(ch_req), .ch_addr_i(ch_addr_flat), .ch_size_i(ch_size_flat),
        .ch_gnt_o(ch_gnt), .ch_valid_o(ch_valid), .ch_data_o(ch_data),
        .l2_req_o(l2_req), .l2_addr_o(l2_addr), .l2_be_o(l2_be), .l2_gnt_i(l2_gnt),
        .l2_rdata_i(l2_rdata), .l2_rvalid_i(l2_rvalid), .rsp_err_o(rsp_err)
    );

    // Reference model: RR pointer as an integer, outstanding reads as queues.
    int m_ptr;
    int q_id[$];
    int q_off[$];
    int q_size[$];
    bit m_err;
    int m_last;

    int              e_win, e_off, e_sz;
    bit              e_req, e_push, e_pop, e_spur;
    logic [N_CH-1:0] e_gnt, e_valid;
    logic [31:0]     e_addr, e_data;
    logic [3:0]      e_be;

    function automatic int rr_winner();
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_ptr + k) % N_CH;
            if (ch_req[c]) return c;
        end
        return -1;
    endfunction

    function automatic int size_bytes(input int sz);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    // Waits for the sampling edge and computes what the DUT should show this cycle.
    task automatic settle();
        int nb;
        @(negedge clk);
        e_win  = rr_winner();
        e_req  = (e_win >= 0) && (q_id.size() < OUTSTD);
        e_push = e_req && (l2_gnt == 1'b1);
        e_gnt  = '0;
        e_addr = '0;
        e_be   = '0;
        e_off  = 0;
        e_sz   = 0;
        if (e_win >= 0) begin
            e_off  = int'(a_addr[e_win] % 4);
            e_sz   = int'(a_size[e_win]);
            e_addr = a_addr[e_win] - (a_addr[e_win] % 4);
            nb     = size_bytes(e_sz);
            e_be   = (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << e_off);
            if (e_push) e_gnt[e_win] = 1'b1;
        end
        e_pop   = (l2_rvalid == 1'b1) && (q_id.size() > 0);
        e_spur  = (l2_rvalid == 1'b1) && (q_id.size() == 0);
        e_valid = '0;
        e_data  = '0;
        if (e_pop) begin
            e_valid[q_id[0]] = 1'b1;
            nb     = size_bytes(q_size[0]);
            e_data = 32'((64'(l2_rdata) >> (8 * q_off[0])) & ((64'd1 << (8 * nb)) - 64'd1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (e_pop) begin
            void'(q_id.pop_front());
            void'(q_off.pop_front());
            void'(q_size.pop_front());
        end
        if (e_push) begin
            q_id.push_back(e_win);
            q_off.push_back(e_off);
            q_size.push_back(e_sz);
            m_ptr = (e_win + 1) % N_CH;
        end
        m_last = e_push ? e_win : -1;
        if (e_spur) m_err = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        ch_req    = '0;
        for (int i = 0; i < N_CH; i++) begin
            a_addr[i] = '0;
            a_size[i] = '0;
        end
        l2_gnt    = 1'b0;
        l2_rvalid = 1'b0;
        l2_rdata  = '0;
        rstn      = 1'b0;
        m_ptr     = 0;
        q_id.delete();
        q_off.delete();
        q_size.delete();
        m_err     = 1'b0;
        m_last    = -1;
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (ch_gnt !== '0) begin failures++; $display("FAIL reset_gnt got %h want 0", ch_gnt); end
        checks++; if (ch_valid !== '0) begin failures++; $display("FAIL reset_valid got %h want 0", ch_valid); end
        checks++; if (ch_data !== '0) begin failures++; $display("FAIL reset_data got %h want 0", ch_data); end
        checks++; if (l2_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", l2_req); end
        checks++; if (l2_addr !== '0) begin failures++; $display("FAIL reset_addr got %h want 0", l2_addr); end
        checks++; if (l2_be !== '0) begin failures++; $display("FAIL reset_be got %b want 0", l2_be); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", rsp_err); end
    endtask

    task automatic test_single();
        do_reset();
        ch_req[4] = 1'b1;
        a_addr[4] = 32'h1C00_1002;
        a_size[4] = 2'd1;
        l2_gnt    = 1'b1;
        settle();
        checks++; if (l2_req !== 1'b1) begin failures++; $display("FAIL single_req got %b want 1", l2_req); end
        checks++; if (l2_addr !== 32'h1C00_1000) begin failures++; $display("FAIL single_addr got %h want 1c001000", l2_addr); end
        checks++; if (l2_be !== 4'b1100) begin failures++; $display("FAIL single_be got %b want 1100", l2_be); end
        checks++; if (ch_gnt !== N_CH'(1) << 4) begin failures++; $display("FAIL single_gnt got %h want %h", ch_gnt, N_CH'(1) << 4); end
        tick();
        ch_req    = '0;
        l2_gnt    = 1'b0;
        l2_rvalid = 1'b1;
        l2_rdata  = 32'hBEEF_1234;
        settle();
        checks++; if (ch_valid !== N_CH'(1) << 4) begin failures++; $display("FAIL single_valid got %h want %h", ch_valid, N_CH'(1) << 4); end
        checks++; if (ch_data !== 32'h0000_BEEF) begin failures++; $display("FAIL single_data got %h want 0000beef", ch_data); end
        tick();
        l2_rvalid = 1'b0;
        settle();
        checks++; if (ch_valid !== '0) begin failures++; $display("FAIL single_valid_after got %h want 0", ch_valid); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL single_err got %b want 0", rsp_err); end
        tick();
    endtask

    task automatic test_rr();
        int order [6] = '{0, 5, 18, 0, 5, 18};
        do_reset();
        ch_req[0]  = 1'b1; a_addr[0]  = 32'h1000_0000; a_size[0]  = 2'd2;
        ch_req[5]  = 1'b1; a_addr[5]  = 32'h1000_0501; a_size[5]  = 2'd0;
        ch_req[18] = 1'b1; a_addr[18] = 32'h1000_1802; a_size[18] = 2'd1;
        l2_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            l2_rvalid = (k > 0);
            l2_rdata  = $urandom;
            settle();
            checks++;
            if (ch_gnt !== N_CH'(1) << order[k]) begin
                failures++; $display("FAIL rr_gnt[%0d] got %h want %h", k, ch_gnt, N_CH'(1) << order[k]);
            end
            if (k > 0) begin
                checks++;
                if (ch_valid !== N_CH'(1) << order[k-1] || ch_data !== e_data) begin
                    failures++;
                    $display("FAIL rr_rsp[%0d] got valid=%h data=%h want valid=%h data=%h",
                             k, ch_valid, ch_data, N_CH'(1) << order[k-1], e_data);
                end
            end
            tick();
        end
        ch_req    = '0;
        l2_rvalid = 1'b1;
        settle();
        checks++; if (ch_valid !== N_CH'(1) << 18) begin failures++; $display("FAIL rr_last_valid got %h want %h", ch_valid, N_CH'(1) << 18); end
        tick();
        l2_rvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        int ngnt = 0;
        int chans [6] = '{1, 2, 3, 7, 9, 11};
        do_reset();
        foreach (chans[i]) begin
            ch_req[chans[i]] = 1'b1;
            a_addr[chans[i]] = $urandom;
            a_size[chans[i]] = 2'd2;
        end
        l2_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (ch_gnt !== '0) ngnt++;
            checks++; if (ch_gnt !== e_gnt) begin failures++; $display("FAIL bp_gnt[%0d] got %h want %h", k, ch_gnt, e_gnt); end
            tick();
        end
        checks++; if (ngnt != 4) begin failures++; $display("FAIL bp_grant_count got %0d want 4", ngnt); end
        settle();
        checks++; if (l2_req !== 1'b0) begin failures++; $display("FAIL bp_req_full got %b want 0", l2_req); end
        tick();
        l2_rvalid = 1'b1;
        l2_rdata  = $urandom;
        settle();
        checks++; if (l2_req !== 1'b0) begin failures++; $display("FAIL bp_no_bypass got %b want 0", l2_req); end
        checks++; if (ch_valid !== N_CH'(1) << 1) begin failures++; $display("FAIL bp_pop_valid got %h want %h", ch_valid, N_CH'(1) << 1); end
        tick();
        l2_rvalid = 1'b0;
        settle();
        checks++; if (l2_req !== 1'b1) begin failures++; $display("FAIL bp_req_reopen got %b want 1", l2_req); end
        tick();
    endtask

    task automatic test_byte();
        do_reset();
        ch_req[2] = 1'b1;
        a_addr[2] = 32'h0000_0103;
        a_size[2] = 2'd0;
        l2_gnt    = 1'b1;
        settle();
        checks++; if (l2_be !== 4'b1000) begin failures++; $display("FAIL byte_be got %b want 1000", l2_be); end
        checks++; if (l2_addr !== 32'h0000_0100) begin failures++; $display("FAIL byte_addr got %h want 00000100", l2_addr); end
        tick();
        ch_req    = '0;
        l2_gnt    = 1'b0;
        l2_rvalid = 1'b1;
        l2_rdata  = 32'hA1B2_C3D4;
        settle();
        checks++; if (ch_data !== 32'h0000_00A1) begin failures++; $display("FAIL byte_data got %h want 000000a1", ch_data); end
        checks++; if (ch_valid !== N_CH'(1) << 2) begin failures++; $display("FAIL byte_valid got %h want %h", ch_valid, N_CH'(1) << 2); end
        tick();
        l2_rvalid = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        l2_rvalid = 1'b1;
        l2_rdata  = $urandom;
        settle();
        checks++; if (ch_valid !== '0) begin failures++; $display("FAIL spur_valid got %h want 0", ch_valid); end
        checks++; if (ch_data !== '0) begin failures++; $display("FAIL spur_data got %h want 0", ch_data); end
        tick();
        l2_rvalid = 1'b0;
        settle();
        checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL spur_err_set got %b want 1", rsp_err); end
        tick();
        ch_req[6] = 1'b1;
        l2_gnt    = 1'b1;
        settle();
        tick();
        ch_req    = '0;
        l2_gnt    = 1'b0;
        l2_rvalid = 1'b1;
        settle();
        tick();
        l2_rvalid = 1'b0;
        settle();
        checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL spur_err_sticky got %b want 1", rsp_err); end
        tick();
        do_reset();
        settle();
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL spur_err_clear got %b want 0", rsp_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        int ngnt = 0;
        do_reset();
        ch_req[3] = 1'b1; ch_req[8] = 1'b1; ch_req[12] = 1'b1;
        l2_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            tick();
        end
        do_reset();
        ch_req[3] = 1'b1; ch_req[8] = 1'b1; ch_req[12] = 1'b1;
        l2_gnt = 1'b1;
        settle();
        checks++; if (ch_gnt !== N_CH'(1) << 3) begin failures++; $display("FAIL mid_first_gnt got %h want %h", ch_gnt, N_CH'(1) << 3); end
        for (int k = 0; k < 6; k++) begin
            if (ch_gnt !== '0) ngnt++;
            tick();
            settle();
        end
        checks++; if (ngnt != OUTSTD) begin failures++; $display("FAIL mid_fifo_flushed got %0d grants want %0d", ngnt, OUTSTD); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_req[i] && m_last == i) begin
                    if ($urandom_range(0, 1) == 0) begin
                        ch_req[i] = 1'b0;
                    end else begin
                        a_addr[i] = $urandom;
                        a_size[i] = 2'($urandom_range(0, 3));
                    end
                end else if (!ch_req[i] && $urandom_range(0, 7) == 0) begin
                    ch_req[i] = 1'b1;
                    a_addr[i] = $urandom;
                    a_size[i] = 2'($urandom_range(0, 3));
                end
            end
            l2_gnt    = ($urandom_range(0, 3) != 0);
            l2_rvalid = (q_id.size() > 0) && ($urandom_range(0, 1) == 1);
            l2_rdata  = $urandom;
            settle();
            checks++;
            if (l2_req !== e_req || ch_gnt !== e_gnt) begin
                failures++;
                $display("FAIL rand_req[%0d] got req=%b gnt=%h want req=%b gnt=%h", cyc, l2_req, ch_gnt, e_req, e_gnt);
            end
            if (e_req) begin
                checks++;
                if (l2_addr !== e_addr || l2_be !== e_be) begin
                    failures++;
                    $display("FAIL rand_addr[%0d] got addr=%h be=%b want addr=%h be=%b", cyc, l2_addr, l2_be, e_addr, e_be);
                end
            end
            checks++;
            if (ch_valid !== e_valid || ch_data !== e_data || rsp_err !== m_err) begin
                failures++;
                $display("FAIL rand_rsp[%0d] got valid=%h data=%h err=%b want valid=%h data=%h err=%b",
                         cyc, ch_valid, ch_data, rsp_err, e_valid, e_data, m_err);
            end
            tick();
        end
    endtask

    initial begin
        ch_req    = '0;
        l2_gnt    = 1'b0;
        l2_rvalid = 1'b0;
        l2_rdata  = '0;
        #1;
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_byte();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
